// File: rtl/dled_scan_ctrl.sv
// -----------------------------------------------------------------------------
// dled_scan_ctrl
//
// Time-multiplexed scan controller for an 8-digit seven-segment LED display.
// It rotates a one-hot digit select and keeps a tear-free shadow copy of the
// 32-bit display word. It also picks the active nibble and encodes it to
// segment drive.
//
// Parameters
//   SCAN_DIV        clock cycles per digit slot (>= 2)
//   SEG_ACTIVE_LOW  1: seg inverted (common anode), 0: lit segment is 1
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   en          scan enable; 0 blanks the display and parks the controller
//   disp_data   display word, nibble k shown on digit k
//   dp_in       decimal point per digit
//   digit_en    per-digit enable; 0 blanks that digit's segments
//   load        single-cycle request to take disp_data/dp_in
//   load_ack    single-cycle pulse when the shadow copy is updated
//   sel         one-hot digit select, bit k selects disp_data[4k+3:4k]
//   data_nib    nibble currently displayed
//   seg         segment drive {dp,g,f,e,d,c,b,a}
//   frame_done  single-cycle pulse at the end of the digit 7 slot
// -----------------------------------------------------------------------------
module dled_scan_ctrl #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] disp_data,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    input  logic        load,
    output logic        load_ack,
    output logic [7:0]  sel,
    output logic [3:0]  data_nib,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    // Fully unlit pattern; XOR with it also applies the polarity to a lit pattern.
    localparam logic [7:0]    SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    sel_q, sel_d;
    logic [3:0]    data_nib_q, data_nib_d;
    logic [7:0]    seg_q, seg_d;
    logic          load_ack_q, load_ack_d;
    logic          frame_done_q, frame_done_d;
    logic [31:0]   shadow_data_q, shadow_data_d;
    logic [7:0]    shadow_dp_q, shadow_dp_d;
    logic [31:0]   stage_data_q, stage_data_d;
    logic [7:0]    stage_dp_q, stage_dp_d;
    logic          pend_q, pend_d;
    logic          commit;
    logic [3:0]    nib_sel;
    logic          dp_sel;
    logic          den_sel;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'h3F;
            4'h1: r = 7'h06;
            4'h2: r = 7'h5B;
            4'h3: r = 7'h4F;
            4'h4: r = 7'h66;
            4'h5: r = 7'h6D;
            4'h6: r = 7'h7D;
            4'h7: r = 7'h07;
            4'h8: r = 7'h7F;
            4'h9: r = 7'h6F;
            4'hA: r = 7'h77;
            4'hB: r = 7'h7C;
            4'hC: r = 7'h39;
            4'hD: r = 7'h5E;
            4'hE: r = 7'h79;
            default: r = 7'h71;
        endcase
        return r;
    endfunction

    // Next-state logic: scan sequencing, load staging and shadow commit.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sel_d         = sel_q;
        frame_done_d  = 1'b0;
        load_ack_d    = 1'b0;
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        stage_data_d  = stage_data_q;
        stage_dp_d    = stage_dp_q;
        pend_d        = pend_q;
        commit        = 1'b0;

        // A repeated load before commit simply overwrites the staging copy.
        if (load) begin
            stage_data_d = disp_data;
            stage_dp_d   = dp_in;
            pend_d       = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                sel_d  = 8'h00;
                // Nothing is being scanned, so tearing is impossible: commit at once.
                commit = pend_d;
                if (en) begin
                    state_d = SCAN;
                    sel_d   = 8'h01;
                end
            end
            default: begin
                if (!en) begin
                    // Pending is deliberately kept across the park.
                    state_d = IDLE;
                    cnt_d   = '0;
                    sel_d   = 8'h00;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (sel_q[7]) begin
                        sel_d        = 8'h01;
                        frame_done_d = 1'b1;
                        // Frame boundary: the only place the shadow may change while scanning.
                        commit       = pend_d;
                    end else begin
                        sel_d = {sel_q[6:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase

        // Using the _d staging values lets a load in the boundary cycle commit on that edge.
        if (commit) begin
            shadow_data_d = stage_data_d;
            shadow_dp_d   = stage_dp_d;
            pend_d        = 1'b0;
            load_ack_d    = 1'b1;
        end
    end

    // Digit mux driven from the next select and next shadow so sel and seg never skew.
    always_comb begin
        nib_sel = 4'h0;
        dp_sel  = 1'b0;
        den_sel = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (sel_d[k]) begin
                nib_sel = nib_sel | shadow_data_d[4*k +: 4];
                dp_sel  = dp_sel  | shadow_dp_d[k];
                den_sel = den_sel | digit_en[k];
            end
        end
        // With no digit selected den_sel is 0, which also blanks seg in IDLE.
        seg_d      = den_sel ? ({dp_sel, hex7(nib_sel)} ^ SEG_OFF) : SEG_OFF;
        data_nib_d = (sel_d == 8'h00) ? data_nib_q : nib_sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sel_q         <= 8'h00;
            data_nib_q    <= 4'h0;
            seg_q         <= SEG_OFF;
            load_ack_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            shadow_data_q <= 32'h0;
            shadow_dp_q   <= 8'h00;
            stage_data_q  <= 32'h0;
            stage_dp_q    <= 8'h00;
            pend_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            data_nib_q    <= data_nib_d;
            seg_q         <= seg_d;
            load_ack_q    <= load_ack_d;
            frame_done_q  <= frame_done_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            stage_data_q  <= stage_data_d;
            stage_dp_q    <= stage_dp_d;
            pend_q        <= pend_d;
        end
    end

    assign sel        = sel_q;
    assign data_nib   = data_nib_q;
    assign seg        = seg_q;
    assign load_ack   = load_ack_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dled_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dled_scan_ctrl
//
// Directed bench for dled_scan_ctrl with SCAN_DIV=4 and active-low segments.
// Inputs are driven on the falling edge and outputs are checked there, so
// every check sees the values settled after the preceding rising edge.
// -----------------------------------------------------------------------------
module tb_dled_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] disp_data;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic        load;
    logic        load_ack;
    logic [7:0]  sel;
    logic [3:0]  data_nib;
    logic [7:0]  seg;
    logic        frame_done;

    int checks = 0;
    int fails  = 0;
    int ack_seen;

    dled_scan_ctrl #(
        .SCAN_DIV      (4),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .disp_data (disp_data),
        .dp_in     (dp_in),
        .digit_en  (digit_en),
        .load      (load),
        .load_ack  (load_ack),
        .sel       (sel),
        .data_nib  (data_nib),
        .seg       (seg),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0;
        disp_data = 32'h0; dp_in = 8'h00; digit_en = 8'hFF;
        cyc(2);
        $display("reset state");
        chk("rst_sel",  32'(sel),        32'h00);
        chk("rst_seg",  32'(seg),        32'hFF);
        chk("rst_nib",  32'(data_nib),   32'h0);
        chk("rst_ack",  32'(load_ack),   32'h0);
        chk("rst_fd",   32'(frame_done), 32'h0);

        rst = 1'b0;
        cyc(1);
        en = 1'b1;
        cyc(1);
        $display("enable: first slot");
        chk("en_sel",   32'(sel),        32'h01);
        chk("en_nib",   32'(data_nib),   32'h0);
        chk("en_seg",   32'(seg),        32'hC0);

        // Load in SCAN, committed only at the first frame boundary.
        load = 1'b1; disp_data = 32'h8765_4321;
        cyc(1);
        load = 1'b0;
        $display("load 87654321 staged");
        chk("l1_noack", 32'(load_ack),   32'h0);
        cyc(30);
        chk("l1_sel80", 32'(sel),        32'h80);
        chk("l1_ack0",  32'(load_ack),   32'h0);
        cyc(1);
        $display("first frame boundary");
        chk("b1_sel",   32'(sel),        32'h01);
        chk("b1_fd",    32'(frame_done), 32'h1);
        chk("b1_ack",   32'(load_ack),   32'h1);
        chk("b1_nib",   32'(data_nib),   32'h1);
        chk("b1_seg",   32'(seg),        32'hF9);
        cyc(1);
        chk("b1_fd_lo", 32'(frame_done), 32'h0);
        chk("b1_ack_lo",32'(load_ack),   32'h0);
        cyc(28);
        $display("digit 7 of new data");
        chk("d7_sel",   32'(sel),        32'h80);
        chk("d7_nib",   32'(data_nib),   32'h8);
        chk("d7_seg",   32'(seg),        32'h80);
        cyc(3);
        chk("b2_fd",    32'(frame_done), 32'h1);
        chk("b2_noack", 32'(load_ack),   32'h0);

        // Mid-frame load while digit 3 is selected.
        cyc(12);
        chk("mid_sel08",32'(sel),        32'h08);
        load = 1'b1; disp_data = 32'hFEDC_BA98;
        cyc(1);
        load = 1'b0;
        $display("mid-frame load FEDCBA98");
        chk("mid_ack0", 32'(load_ack),   32'h0);
        chk("mid_nib4", 32'(data_nib),   32'h4);
        cyc(3);
        chk("mid_nib5", 32'(data_nib),   32'h5);
        cyc(12);
        chk("mid_nib8", 32'(data_nib),   32'h8);
        cyc(3);
        chk("mid_ack_pre", 32'(load_ack), 32'h0);
        cyc(1);
        $display("boundary commit of mid-frame load");
        chk("b3_ack",   32'(load_ack),   32'h1);
        chk("b3_sel",   32'(sel),        32'h01);
        chk("b3_nib",   32'(data_nib),   32'h8);
        chk("b3_seg",   32'(seg),        32'h80);

        // Digit blanking and decimal point.
        load = 1'b1; disp_data = 32'h8765_4321; dp_in = 8'h02; digit_en = 8'hFE;
        cyc(1);
        load = 1'b0;
        $display("digit_en=FE dp_in=02");
        chk("blk_seg",  32'(seg),        32'hFF);
        chk("blk_sel",  32'(sel),        32'h01);
        cyc(31);
        chk("blk_ack",  32'(load_ack),   32'h1);
        chk("blk_nib",  32'(data_nib),   32'h1);
        chk("blk_seg2", 32'(seg),        32'hFF);
        cyc(4);
        chk("dp_sel",   32'(sel),        32'h02);
        chk("dp_nib",   32'(data_nib),   32'h2);
        chk("dp_seg",   32'(seg),        32'h24);

        // Drop enable while digit 4 is selected.
        cyc(12);
        chk("park_sel10", 32'(sel),      32'h10);
        digit_en = 8'hFF; en = 1'b0;
        cyc(1);
        $display("enable dropped");
        chk("park_sel", 32'(sel),        32'h00);
        chk("park_seg", 32'(seg),        32'hFF);
        cyc(2);
        chk("park_hold",32'(sel),        32'h00);
        en = 1'b1;
        cyc(1);
        $display("re-enable");
        chk("re_sel",   32'(sel),        32'h01);
        chk("re_seg",   32'(seg),        32'hF9);
        cyc(3);
        chk("re_slot",  32'(sel),        32'h01);
        cyc(1);
        chk("re_sel02", 32'(sel),        32'h02);
        chk("re_seg02", 32'(seg),        32'h24);

        // Load while parked commits on the next edge.
        en = 1'b0;
        cyc(1);
        load = 1'b1; disp_data = 32'hCAFE_F00D; dp_in = 8'h00;
        cyc(1);
        load = 1'b0;
        $display("IDLE load CAFEF00D");
        chk("idle_ack", 32'(load_ack),   32'h1);
        chk("idle_sel", 32'(sel),        32'h00);
        cyc(1);
        chk("idle_ack_lo", 32'(load_ack), 32'h0);
        en = 1'b1;
        cyc(1);
        chk("idle_nib", 32'(data_nib),   32'hD);
        chk("idle_seg", 32'(seg),        32'hA1);

        // Double load pulse in one frame: single ack with last data.
        load = 1'b1; disp_data = 32'h1234_5678;
        cyc(1);
        disp_data = 32'h9ABC_DEF0;
        cyc(1);
        load = 1'b0;
        $display("double load");
        chk("dbl_ack0", 32'(load_ack),   32'h0);
        cyc(29);
        chk("dbl_ack_pre", 32'(load_ack), 32'h0);
        cyc(1);
        chk("dbl_ack",  32'(load_ack),   32'h1);
        chk("dbl_fd",   32'(frame_done), 32'h1);
        chk("dbl_nib",  32'(data_nib),   32'h0);
        chk("dbl_seg",  32'(seg),        32'hC0);
        cyc(1);
        chk("dbl_ack_lo", 32'(load_ack), 32'h0);
        cyc(31);
        chk("dbl_fd2",  32'(frame_done), 32'h1);
        chk("dbl_noack2", 32'(load_ack), 32'h0);

        // Load in the boundary cycle itself.
        cyc(31);
        chk("bl_sel80", 32'(sel),        32'h80);
        load = 1'b1; disp_data = 32'h0000_0005;
        cyc(1);
        load = 1'b0;
        $display("load on boundary cycle");
        chk("bl_ack",   32'(load_ack),   32'h1);
        chk("bl_nib",   32'(data_nib),   32'h5);
        chk("bl_seg",   32'(seg),        32'h92);
        cyc(1);
        chk("bl_ack_lo",32'(load_ack),   32'h0);

        // Reset mid-slot with a load pending.
        load = 1'b1; disp_data = 32'h7777_7777;
        cyc(1);
        load = 1'b0;
        cyc(1);
        rst = 1'b1;
        #1;
        $display("async reset mid-slot");
        chk("ar_sel",   32'(sel),        32'h00);
        chk("ar_seg",   32'(seg),        32'hFF);
        chk("ar_nib",   32'(data_nib),   32'h0);
        chk("ar_ack",   32'(load_ack),   32'h0);
        chk("ar_fd",    32'(frame_done), 32'h0);
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("ar_rel_sel", 32'(sel),      32'h01);
        chk("ar_rel_nib", 32'(data_nib), 32'h0);
        ack_seen = 0;
        for (int i = 0; i < 39; i++) begin
            cyc(1);
            if (load_ack) ack_seen++;
        end
        $display("post-reset ack watch");
        chk("ar_no_ack", 32'(ack_seen),  32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
